ddr3_status_monitor: RTL
========================

// Module: ddr3_status_monitor
// PURPOSE
//  Conditions the raw DDR3 controller status signals (init done, cal success, cal fail) for the
//  system clock domain. Synchronises, glitch-filters, watches for calibration timeout and loss of
//  ready, and produces the 3-bit status word that feeds the DDR3 status PIO (in_port[2:0]).
//  Sits between the UniPHY/controller status outputs and the Avalon status PIO.
// PARAMETERS
//  SYNC_STAGES     2        synchroniser flops per raw input (>=2)
//  FILTER_CYCLES   4        consecutive stable cycles needed before a filtered bit changes (>=1)
//  TIMEOUT_CYCLES  1000000  cycles allowed in WAIT_INIT before TIMEOUT (20 ms at 50 MHz)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  raw_init_done  in   1  controller local_init_done, asynchronous to clk
//  raw_cal_succ   in   1  controller local_cal_success, asynchronous
//  raw_cal_fail   in   1  controller local_cal_fail, asynchronous
//  clr_error      in   1  1-cycle pulse: leave FAILED/TIMEOUT, restart monitoring
//  status_out     out  3  [0]=filtered init_done, [1]=state==READY, [2]=state==FAILED|TIMEOUT
//  state_out      out  2  0=WAIT_INIT 1=READY 2=FAILED 3=TIMEOUT
//  lost_ready     out  1  sticky: READY was left due to status drop/fail
//  error_count    out  8  saturating count of entries into FAILED or TIMEOUT
// BEHAVIOUR
//  Reset: all sync flops, filtered bits, filter counters, timer = 0; state=WAIT_INIT;
//   status_out=3'b000, state_out=0, lost_ready=0, error_count=0. All outputs are decodes of registers.
//  Sync: each raw bit through SYNC_STAGES flops; no other logic before the last stage.
//  Filter (per bit): counter clears while synced==filtered; increments while they differ;
//   filtered takes synced value on the FILTER_CYCLES-th consecutive differing cycle, counter clears.
//   Input-to-filtered latency = SYNC_STAGES+FILTER_CYCLES clks; shorter pulses are ignored.
//  Timer: counts only in WAIT_INIT, clears on any state change; width $clog2(TIMEOUT_CYCLES+1).
//  FSM, evaluated each clk on filtered bits (priority top-down):
//   WAIT_INIT: f_fail -> FAILED; else f_init&f_succ -> READY;
//              else timer==TIMEOUT_CYCLES-1 -> TIMEOUT; else stay.
//   READY:     f_fail | !f_init | !f_succ -> FAILED, set lost_ready. clr_error ignored.
//   FAILED, TIMEOUT: clr_error -> WAIT_INIT (timer 0); else stay. Not left on status recovery.
//  clr_error also clears lost_ready in any state; clr_error with a simultaneous set of lost_ready
//   (READY exit) -> set wins.
//  clr_error in FAILED with f_fail still 1 -> WAIT_INIT for one cycle, then FAILED again
//   (error_count increments again).
//  error_count += 1 on each transition into FAILED or TIMEOUT; holds at 255.
//  status_out/state_out change in the same cycle as the state register.
//  Reset mid-operation: everything returns to reset values next clk; no state retained.
// TESTING
//  1 raw init&succ rise at t0, no fail -> status_out=3'b011 at t0+6 clks (defaults), error_count=0.
//  2 raw_cal_fail 3-cycle glitch while WAIT_INIT -> no state change; 4+ cycles -> FAILED,
//    status_out=3'b1x0, error_count=1.
//  3 status never rises, TIMEOUT_CYCLES=100 -> TIMEOUT at cycle 100 after reset; clr_error ->
//    WAIT_INIT, timer restarts, TIMEOUT again at +100, error_count=2.
//  4 in READY drop raw_init_done >=6 clks -> FAILED, lost_ready=1; clr_error -> lost_ready=0.
//  5 fail held high, 300 clr_error pulses -> error_count saturates at 255.
//  6 assert reset while READY with lost_ready=1 -> next clk all outputs 0, state WAIT_INIT.

Source files
------------

// File: rtl/ddr3_status_if.sv
// Status bundle between the DDR3 controller status lines / status PIO and the monitor.
// Raw inputs and clr_error come from the outside world; the conditioned outputs go back out.
interface ddr3_status_if;
    logic       raw_init_done;
    logic       raw_cal_succ;
    logic       raw_cal_fail;
    logic       clr_error;
    logic [2:0] status_out;
    logic [1:0] state_out;
    logic       lost_ready;
    logic [7:0] error_count;

    modport master (
        output raw_init_done,
        output raw_cal_succ,
        output raw_cal_fail,
        output clr_error,
        input  status_out,
        input  state_out,
        input  lost_ready,
        input  error_count
    );

    modport slave (
        input  raw_init_done,
        input  raw_cal_succ,
        input  raw_cal_fail,
        input  clr_error,
        output status_out,
        output state_out,
        output lost_ready,
        output error_count
    );
endinterface

// File: rtl/ddr3_status_monitor.sv
// DDR3 status conditioner: synchronises and glitch-filters the controller status lines, tracks
// calibration progress (wait / ready / failed / timeout) and builds the 3-bit status PIO word.
module ddr3_status_monitor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    ddr3_status_if.slave     bus
);
    localparam int unsigned FcW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int unsigned TmW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FcW-1:0] FcLast = FcW'(FILTER_CYCLES - 1);
    localparam logic [TmW-1:0] TmLast = TmW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitInit = 2'd0,
        StReady    = 2'd1,
        StFailed   = 2'd2,
        StTimeout  = 2'd3
    } state_e;

    // Bit order used throughout: [0]=init_done, [1]=cal_success, [2]=cal_fail
    logic [2:0] raw;
    assign raw = {bus.raw_cal_fail, bus.raw_cal_succ, bus.raw_init_done};

    logic [SYNC_STAGES-1:0] sync_q [3];
    logic [SYNC_STAGES-1:0] sync_d [3];
    logic [FcW-1:0]         fcnt_q [3];
    logic [FcW-1:0]         fcnt_d [3];
    logic [2:0]             synced;
    logic [2:0]             filt_q, filt_d;
    logic [TmW-1:0]         timer_q, timer_d;
    state_e                 state_q, state_d;
    logic                   lost_q, lost_d;
    logic [7:0]             err_q, err_d;
    logic                   f_init, f_succ, f_fail;
    logic                   set_lost;

    // Synchroniser shift and per-bit stability filter
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            synced[i] = sync_q[i][SYNC_STAGES-1];
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (synced[i] != filt_q[i]) begin
                if (fcnt_q[i] == FcLast) begin
                    filt_d[i] = synced[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FcW'(1);
                end
            end
        end
    end

    // FSM acts on the freshly filtered values so status tracks the filter in the same clock
    assign f_init = filt_d[0];
    assign f_succ = filt_d[1];
    assign f_fail = filt_d[2];

    // Next-state, timeout timer, lost_ready and error counter
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        lost_d   = lost_q;
        err_d    = err_q;
        set_lost = 1'b0;

        unique case (state_q)
            StWaitInit: begin
                if (f_fail) begin
                    state_d = StFailed;
                end else if (f_init && f_succ) begin
                    state_d = StReady;
                end else if (timer_q == TmLast) begin
                    state_d = StTimeout;
                end else begin
                    timer_d = timer_q + TmW'(1);
                end
            end
            StReady: begin
                if (f_fail || !f_init || !f_succ) begin
                    state_d  = StFailed;
                    set_lost = 1'b1;
                end
            end
            StFailed, StTimeout: begin
                if (bus.clr_error) begin
                    state_d = StWaitInit;
                end
            end
        endcase

        // A READY exit in the same cycle as clr_error keeps the flag set
        if (bus.clr_error) begin
            lost_d = 1'b0;
        end
        if (set_lost) begin
            lost_d = 1'b1;
        end

        if ((state_d != state_q) && ((state_d == StFailed) || (state_d == StTimeout)) &&
            (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= '0;
                fcnt_q[i] <= '0;
            end
            filt_q  <= '0;
            timer_q <= '0;
            state_q <= StWaitInit;
            lost_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= sync_d[i];
                fcnt_q[i] <= fcnt_d[i];
            end
            filt_q  <= filt_d;
            timer_q <= timer_d;
            state_q <= state_d;
            lost_q  <= lost_d;
            err_q   <= err_d;
        end
    end

    assign bus.status_out  = {(state_q == StFailed) || (state_q == StTimeout),
                              state_q == StReady, filt_q[0]};
    assign bus.state_out   = state_q;
    assign bus.lost_ready  = lost_q;
    assign bus.error_count = err_q;
endmodule
